// File: rtl/aes_pkg.sv
// Shared AES definitions: key-expansion state codes, sizing constants and the
// GF(2^8) doubling helper used for the round-constant sequence.
package aes_pkg;

    typedef enum logic [1:0] {
        KE_IDLE   = 2'd0,
        KE_LOAD   = 2'd1,
        KE_EXPAND = 2'd2,
        KE_DONE   = 2'd3
    } ke_state_e;

    localparam int NUM_ROUNDS = 10;
    localparam int NUM_WORDS  = 4 * (NUM_ROUNDS + 1);

    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1b;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/key_expand_ctrl_if.sv
// Bundle between the state manager / AddRoundKey datapath and the key-expansion
// controller.
interface key_expand_ctrl_if;

    // key_start is a one-cycle pulse with no ready: the controller accepts it
    // only in IDLE or DONE and ignores it otherwise; key_word_in is sampled on
    // the four cycles after an accepted pulse; key_expand_done is a level that
    // holds until the next accepted start or reset.
    logic        key_start;
    logic [31:0] key_word_in;
    logic [3:0]  rk_round;
    logic [1:0]  rk_col;
    logic [31:0] rk_word;
    logic        key_expand_done;
    logic        busy;
    logic [1:0]  dbg_state;
    logic [5:0]  dbg_word_idx;

    modport master (
        output key_start, key_word_in, rk_round, rk_col,
        input  rk_word, key_expand_done, busy, dbg_state, dbg_word_idx
    );

    modport slave (
        input  key_start, key_word_in, rk_round, rk_col,
        output rk_word, key_expand_done, busy, dbg_state, dbg_word_idx
    );

endinterface

// File: rtl/aes_sub_word.sv
// Combinational SubWord: the AES S-box applied to each byte of a 32-bit word.
module aes_sub_word (
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign word_out = {SBOX[word_in[31:24]], SBOX[word_in[23:16]],
                       SBOX[word_in[15:8]],  SBOX[word_in[7:0]]};

endmodule

// File: rtl/key_expand_ctrl.sv
// AES-128 key-expansion sequencer: captures four key words, generates the 44
// round-key words one per clock into a register file, then reports done.
module key_expand_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic             clock,
    input  logic             reset,
    key_expand_ctrl_if.slave ke
);

    localparam int NW = 4 * (NUM_ROUNDS + 1);

    ke_state_e   state_q, state_d;
    logic [5:0]  word_idx_q, word_idx_d;
    logic [7:0]  rcon_q, rcon_d;
    logic [31:0] rf_q [NW];
    logic [31:0] rf_d [NW];

    logic        wr_en;
    logic [31:0] wr_data;
    logic [5:0]  idx_m1, idx_m4;
    logic [31:0] prev_word, back4_word, rot_word, sub_word, temp_word;
    logic [5:0]  rd_idx;

    // Recurrence operands: w[i-1] and w[i-4], guarded against wrap at small i.
    always_comb begin
        idx_m1     = word_idx_q - 6'd1;
        idx_m4     = word_idx_q - 6'd4;
        prev_word  = (idx_m1 < 6'(NW)) ? rf_q[idx_m1] : 32'h0;
        back4_word = (idx_m4 < 6'(NW)) ? rf_q[idx_m4] : 32'h0;
        rot_word   = {prev_word[23:0], prev_word[31:24]};
    end

    aes_sub_word u_sub_word (
        .word_in  (rot_word),
        .word_out (sub_word)
    );

    assign temp_word = (word_idx_q[1:0] == 2'b00) ? (sub_word ^ {rcon_q, 24'h0})
                                                  : prev_word;

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        rcon_d     = rcon_q;
        wr_en      = 1'b0;
        wr_data    = 32'h0;
        case (state_q)
            KE_IDLE, KE_DONE: begin
                if (ke.key_start) begin
                    state_d    = KE_LOAD;
                    word_idx_d = 6'd0;
                    rcon_d     = RCON_INIT;
                end
            end
            KE_LOAD: begin
                wr_en      = 1'b1;
                wr_data    = ke.key_word_in;
                word_idx_d = word_idx_q + 6'd1;
                if (word_idx_q == 6'd3) begin
                    state_d = KE_EXPAND;
                end
            end
            KE_EXPAND: begin
                wr_en      = 1'b1;
                wr_data    = back4_word ^ temp_word;
                word_idx_d = word_idx_q + 6'd1;
                if (word_idx_q[1:0] == 2'b00) begin
                    rcon_d = xtime(rcon_q);
                end
                if (word_idx_q == 6'(NW - 1)) begin
                    state_d = KE_DONE;
                end
            end
            default: begin
                state_d = KE_IDLE;
            end
        endcase
    end

    always_comb begin
        rf_d = rf_q;
        if (wr_en) begin
            rf_d[word_idx_q] = wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= KE_IDLE;
            word_idx_q <= 6'd0;
            rcon_q     <= RCON_INIT;
            for (int k = 0; k < NW; k++) begin
                rf_q[k] <= 32'h0;
            end
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            rcon_q     <= rcon_d;
            rf_q       <= rf_d;
        end
    end

    // Round-major layout makes {round, col} the flat word address directly.
    assign rd_idx = {ke.rk_round, ke.rk_col};

    assign ke.rk_word         = (ke.rk_round <= 4'(NUM_ROUNDS)) ? rf_q[rd_idx] : 32'h0;
    assign ke.key_expand_done = (state_q == KE_DONE);
    assign ke.busy            = (state_q == KE_LOAD) || (state_q == KE_EXPAND);
    assign ke.dbg_state       = state_q;
    assign ke.dbg_word_idx    = word_idx_q;

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Bench for key_expand_ctrl: FIPS-197 and all-zero key vectors, mid-expansion
// reset, ignored restarts, rcon and word-index monitoring.
module tb_key_expand_ctrl;

    logic clock = 1'b0;
    logic reset;

    key_expand_ctrl_if ke_if ();

    key_expand_ctrl #(.NUM_ROUNDS(10)) dut (
        .clock (clock),
        .reset (reset),
        .ke    (ke_if)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];
    logic [5:0]  addr_q [$];
    int          lat_q [$];
    logic [7:0]  rcon_tab [10];

    logic [31:0] fips_key [4];
    logic [31:0] zero_key [4];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push_expect(input int round, input int col, input logic [31:0] value);
        addr_q.push_back({4'(round), 2'(col)});
        exp_q.push_back(value);
    endtask

    task automatic push_round(input int round, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d);
        push_expect(round, 0, a);
        push_expect(round, 1, b);
        push_expect(round, 2, c);
        push_expect(round, 3, d);
    endtask

    task automatic drain_reads();
        logic [5:0] a;
        logic [31:0] e;
        while (exp_q.size() > 0) begin
            a = addr_q.pop_front();
            e = exp_q.pop_front();
            ke_if.rk_round = a[5:2];
            ke_if.rk_col   = a[1:0];
            #1;
            check($sformatf("rk r%0d c%0d", a[5:2], a[1:0]), ke_if.rk_word, e);
        end
    endtask

    // Pulse key_start, feed the key on the following four cycles, then wait for
    // done. Optionally re-pulse key_start or assert reset at a given cycle.
    task automatic drive_key(input logic [31:0] k0, input logic [31:0] k1,
                             input logic [31:0] k2, input logic [31:0] k3,
                             input int inject_at, input int reset_at,
                             output int lat);
        lat = 0;
        @(posedge clock);
        #1;
        ke_if.key_start = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clock);
            #1;
            ke_if.key_start = (c == inject_at);
            case (c)
                1:       ke_if.key_word_in = k0;
                2:       ke_if.key_word_in = k1;
                3:       ke_if.key_word_in = k2;
                4:       ke_if.key_word_in = k3;
                default: ke_if.key_word_in = $urandom;
            endcase
            if (c == 1) begin
                check("done_low_after_start", {31'h0, ke_if.key_expand_done}, 32'h0);
            end
            if (c == reset_at) begin
                reset = 1'b1;
                break;
            end
            if (ke_if.key_expand_done) begin
                lat = c;
                break;
            end
        end
        ke_if.key_start = 1'b0;
    endtask

    task automatic check_latency(input int lat);
        int e;
        e = lat_q.pop_front();
        check("done_latency", 32'(lat), 32'(e));
    endtask

    // Monitor: rcon at every SubWord step and contiguous word indices.
    logic [1:0] prev_state = 2'd0;
    logic [5:0] prev_idx   = 6'd0;
    always @(negedge clock) begin
        int exp_idx;
        if (ke_if.dbg_state == 2'd2 && ke_if.dbg_word_idx[1:0] == 2'b00) begin
            check($sformatf("rcon i%0d", ke_if.dbg_word_idx), {24'h0, dut.rcon_q},
                  {24'h0, rcon_tab[int'(ke_if.dbg_word_idx) / 4 - 1]});
        end
        if (ke_if.dbg_state == 2'd1 || ke_if.dbg_state == 2'd2) begin
            exp_idx = (prev_state == 2'd1 || prev_state == 2'd2) ? int'(prev_idx) + 1 : 0;
            check("word_idx_step", {26'h0, ke_if.dbg_word_idx}, 32'(exp_idx));
        end
        prev_state = ke_if.dbg_state;
        prev_idx   = ke_if.dbg_word_idx;
    end

    initial begin
        int lat;
        logic [7:0] r;

        fips_key = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
        zero_key = '{32'h0, 32'h0, 32'h0, 32'h0};
        r = 8'h01;
        for (int k = 0; k < 10; k++) begin
            rcon_tab[k] = r;
            r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
        end

        reset             = 1'b1;
        ke_if.key_start   = 1'b0;
        ke_if.key_word_in = 32'h0;
        ke_if.rk_round    = 4'd0;
        ke_if.rk_col      = 2'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_state", {30'h0, ke_if.dbg_state}, 32'h0);
        check("rst_busy", {31'h0, ke_if.busy}, 32'h0);
        check("rst_done", {31'h0, ke_if.key_expand_done}, 32'h0);
        check("rst_idx", {26'h0, ke_if.dbg_word_idx}, 32'h0);
        check("rst_rk", ke_if.rk_word, 32'h0);
        reset = 1'b0;

        // FIPS-197 key expansion.
        lat_q.push_back(45);
        push_round(0, fips_key[0], fips_key[1], fips_key[2], fips_key[3]);
        push_round(1, 32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605);
        push_round(10, 32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6);
        push_expect(11, 0, 32'h0);
        push_expect(15, 3, 32'h0);
        drive_key(fips_key[0], fips_key[1], fips_key[2], fips_key[3], 0, 0, lat);
        check_latency(lat);
        drain_reads();

        // Reset mid-EXPAND clears everything.
        drive_key(fips_key[0], fips_key[1], fips_key[2], fips_key[3], 0, 20, lat);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("mid_rst_state", {30'h0, ke_if.dbg_state}, 32'h0);
        check("mid_rst_busy", {31'h0, ke_if.busy}, 32'h0);
        check("mid_rst_done", {31'h0, ke_if.key_expand_done}, 32'h0);
        check("mid_rst_idx", {26'h0, ke_if.dbg_word_idx}, 32'h0);
        for (int rd = 0; rd <= 10; rd++) begin
            for (int cl = 0; cl < 4; cl++) begin
                push_expect(rd, cl, 32'h0);
            end
        end
        drain_reads();

        lat_q.push_back(45);
        push_round(1, 32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605);
        push_round(10, 32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6);
        drive_key(fips_key[0], fips_key[1], fips_key[2], fips_key[3], 0, 0, lat);
        check_latency(lat);
        drain_reads();

        // Restart from DONE with the all-zero key.
        lat_q.push_back(45);
        push_round(0, 32'h0, 32'h0, 32'h0, 32'h0);
        push_round(1, 32'h62636363, 32'h62636363, 32'h62636363, 32'h62636363);
        push_round(10, 32'hb4ef5bcb, 32'h3e92e211, 32'h23e951cf, 32'h6f8f188e);
        drive_key(zero_key[0], zero_key[1], zero_key[2], zero_key[3], 0, 0, lat);
        check_latency(lat);
        drain_reads();

        // key_start pulsed during EXPAND must be ignored.
        lat_q.push_back(45);
        push_round(0, fips_key[0], fips_key[1], fips_key[2], fips_key[3]);
        push_round(10, 32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6);
        drive_key(fips_key[0], fips_key[1], fips_key[2], fips_key[3], 20, 0, lat);
        check_latency(lat);
        drain_reads();

        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
